frag_mem_ctrl: RTL and testbench

FRAG_MEM_CTRL -- requirements
Module: frag_mem_ctrl

---
 rtl/frag_pkg.sv | 28 ++
 rtl/frag_ram.sv | 47 ++++
 rtl/frag_mem_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_frag_mem_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frag_pkg.sv
// ---------------------------------------------------------------------------
// frag_pkg
// Shared definitions for the fragment memory controller slice.
//   - wr_mode_e : addressing mode of the byte write channel (DIRECT/STREAM)
//   - off_bits  : number of byte-offset bits inside one fragment
//   - frag_bits : number of fragment-index bits
// No ports (package).
// ---------------------------------------------------------------------------
package frag_pkg;

    // DIRECT uses the address presented with each beat, STREAM uses the
    // internal auto-increment pointer.
    typedef enum logic {
        DIRECT = 1'b0,
        STREAM = 1'b1
    } wr_mode_e;

    // Width of the byte offset within a fragment.
    function automatic int off_bits(input int frag_bytes);
        return $clog2(frag_bytes);
    endfunction

    // Width of the fragment index.
    function automatic int frag_bits(input int nfrag);
        return $clog2(nfrag);
    endfunction

endpackage

// File: rtl/frag_ram.sv
// ---------------------------------------------------------------------------
// frag_ram
// Fragment-wide storage: one write port with per-byte enables and one read
// port with a single cycle of synchronous read latency. Contents are never
// reset so the block can be swapped for a memory-compiler macro.
// Ports:
//   clk : clock
//   we  : write enable          wa : write fragment index
//   be  : byte enables          wd : write data (one fragment wide)
//   re  : read enable           ra : read fragment index
//   rd  : read data, valid the cycle after re
// ---------------------------------------------------------------------------
module frag_ram
    import frag_pkg::*;
#(
    parameter int FRAG_BYTES = 32,
    parameter int NFRAG      = 128
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [frag_bits(NFRAG)-1:0]   wa,
    input  logic [FRAG_BYTES-1:0]         be,
    input  logic [8*FRAG_BYTES-1:0]       wd,
    input  logic                          re,
    input  logic [frag_bits(NFRAG)-1:0]   ra,
    output logic [8*FRAG_BYTES-1:0]       rd
);

    logic [8*FRAG_BYTES-1:0] mem [NFRAG];

    // Byte-lane write and registered read share one clock edge. A read and
    // a write to the same fragment in the same cycle are prevented upstream,
    // so read-during-write behaviour never matters here.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < FRAG_BYTES; i++) begin
                if (be[i]) begin
                    mem[wa][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
        if (re) begin
            rd <= mem[ra];
        end
    end

endmodule

// File: rtl/frag_mem_ctrl.sv
// ---------------------------------------------------------------------------
// frag_mem_ctrl
// Byte-write / fragment-read memory controller with per-fragment completion
// tracking and an auto-increment (stream) write mode.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   wr_valid/wr_ready   : byte write handshake
//   wr_addr, wr_data    : byte address and data
//   wr_stream           : 1 = auto-increment addressing
//   rd_req/rd_ready     : fragment read request handshake
//   rd_frag             : fragment index to read
//   rd_valid            : read response strobe, two cycles after accept
//   rd_data, rd_err     : fragment data and "fragment not complete" flag,
//                         held until the next response
//   frag_done           : one-cycle pulse after the last byte of a fragment
//   clr                 : clear all completion state, return to DIRECT
// ---------------------------------------------------------------------------
module frag_mem_ctrl
    import frag_pkg::*;
#(
    parameter int FRAG_BYTES = 32,
    parameter int NFRAG      = 128,
    parameter int AW         = 16,
    parameter int RD_LAT     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [AW-1:0]                 wr_addr,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_stream,
    input  logic                          rd_req,
    output logic                          rd_ready,
    input  logic [frag_bits(NFRAG)-1:0]   rd_frag,
    output logic                          rd_valid,
    output logic [8*FRAG_BYTES-1:0]       rd_data,
    output logic                          rd_err,
    output logic                          frag_done,
    input  logic                          clr
);

    localparam int OW = off_bits(FRAG_BYTES);
    localparam int FW = frag_bits(NFRAG);
    localparam int MW = OW + FW;
    localparam int DW = 8 * FRAG_BYTES;
    localparam logic [OW-1:0] LAST_OFF = OW'(FRAG_BYTES - 1);

    wr_mode_e          state;
    wr_mode_e          next_state;
    logic [MW-1:0]     ptr;
    logic [MW-1:0]     eff_addr;
    logic [OW-1:0]     eff_off;
    logic [FW-1:0]     eff_frag;
    logic              wr_acc;
    logic              rd_acc;
    logic [NFRAG-1:0]  done;
    logic [FRAG_BYTES-1:0] ram_be;
    logic [DW-1:0]     ram_wd;
    logic [DW-1:0]     ram_rd;
    logic [RD_LAT-1:0] vld_pipe;
    logic              err_s1;
    logic [DW-1:0]     rd_data_q;
    logic              rd_err_q;
    logic              frag_done_q;

    // Address bits above the memory size are deliberately ignored.
    generate
        if (AW > MW) begin : g_upper_addr
            logic unused_upper_addr;
            assign unused_upper_addr = ^wr_addr[AW-1:MW];
        end
    endgenerate

    // Handshakes. A write always wins over a read that targets the fragment
    // the write is about to modify, which keeps the RAM free of same-cycle
    // read/write collisions and makes new data visible to the next read.
    assign wr_ready = ~rst;
    assign wr_acc   = wr_valid & wr_ready;
    assign rd_ready = ~rst & ~(wr_valid && (eff_frag == rd_frag));
    assign rd_acc   = rd_req & rd_ready;

    assign eff_off  = eff_addr[OW-1:0];
    assign eff_frag = eff_addr[MW-1:OW];

    // Addressing FSM, combinational half: choose the effective byte address
    // for this beat and the mode for the next one. A beat with wr_stream=0
    // always falls back to DIRECT; clr overrides everything.
    always_comb begin
        next_state = state;
        eff_addr   = wr_addr[MW-1:0];
        if (state == STREAM && wr_stream) begin
            eff_addr = ptr;
        end
        if (wr_acc) begin
            next_state = wr_stream ? STREAM : DIRECT;
        end
        if (clr) begin
            next_state = DIRECT;
        end
    end

    // Addressing FSM, register half. The pointer is reloaded with the
    // address after every accepted beat; it only matters while in STREAM and
    // wraps naturally at the top of memory because it is exactly MW bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIRECT;
            ptr   <= '0;
        end else begin
            state <= next_state;
            if (wr_acc) begin
                ptr <= eff_addr + 1'b1;
            end
        end
    end

    // Build the single-byte write for the RAM: replicate the byte on every
    // lane and enable only the lane at the effective offset.
    always_comb begin
        ram_be          = '0;
        ram_be[eff_off] = 1'b1;
        ram_wd          = {FRAG_BYTES{wr_data}};
    end

    // Per-fragment completion bits. Writing the first byte reopens a
    // fragment, writing the last byte completes it, and clr wipes all of
    // them even if a completing write lands in the same cycle. The
    // frag_done pulse is independent of clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            done        <= '0;
            frag_done_q <= 1'b0;
        end else begin
            frag_done_q <= wr_acc && (eff_off == LAST_OFF);
            if (wr_acc) begin
                if (eff_off == '0) begin
                    done[eff_frag] <= 1'b0;
                end else if (eff_off == LAST_OFF) begin
                    done[eff_frag] <= 1'b1;
                end
            end
            if (clr) begin
                done <= '0;
            end
        end
    end

    frag_ram #(
        .FRAG_BYTES (FRAG_BYTES),
        .NFRAG      (NFRAG)
    ) u_ram (
        .clk (clk),
        .we  (wr_acc),
        .wa  (eff_frag),
        .be  (ram_be),
        .wd  (ram_wd),
        .re  (rd_acc),
        .ra  (rd_frag),
        .rd  (ram_rd)
    );

    // Read pipeline: stage 1 is the RAM's own read register (the error flag
    // travels alongside it), stage 2 is the output register here. Output
    // data and error only change when a response arrives, so they hold
    // between responses. Reset drops anything still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            err_s1    <= 1'b0;
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[RD_LAT-2:0], rd_acc};
            if (rd_acc) begin
                err_s1 <= ~done[rd_frag];
            end
            if (vld_pipe[0]) begin
                rd_data_q <= ram_rd;
                rd_err_q  <= err_s1;
            end
        end
    end

    // Outputs are forced low for the whole of every reset cycle, including
    // the first one before the reset edge has been seen.
    assign rd_valid  = vld_pipe[RD_LAT-1] & ~rst;
    assign rd_data   = rst ? '0 : rd_data_q;
    assign rd_err    = rd_err_q & ~rst;
    assign frag_done = frag_done_q & ~rst;

endmodule

// File: tb/tb_frag_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frag_mem_ctrl
// Self-checking bench for frag_mem_ctrl: directed scenarios followed by
// randomized traffic, all checked every cycle against a byte-array model.
// No ports.
// ---------------------------------------------------------------------------
module tb_frag_mem_ctrl;

    localparam int FB   = 32;
    localparam int NF   = 128;
    localparam int AW   = 16;
    localparam int MEMB = FB * NF;
    localparam int DW   = 8 * FB;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic [DW-1:0] mask;
        bit            err;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_stream;
    logic          rd_req;
    logic          rd_ready;
    logic [6:0]    rd_frag;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_err;
    logic          frag_done;
    logic          clr;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0]    mem_m   [MEMB];
    bit            known_m [MEMB];
    bit            done_m  [NF];
    bit            in_stream = 1'b0;
    int            next_ptr  = 0;
    bit            fd_next   = 1'b0;
    resp_t         pend [$];
    logic [DW-1:0] last_data = '0;
    logic [DW-1:0] last_mask = '1;
    bit            last_err  = 1'b0;

    int pick_frag [6] = '{0, 1, 2, 3, 126, 127};

    always #5 clk = ~clk;

    frag_mem_ctrl #(
        .FRAG_BYTES (FB),
        .NFRAG      (NF),
        .AW         (AW),
        .RD_LAT     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_stream (wr_stream),
        .rd_req    (rd_req),
        .rd_ready  (rd_ready),
        .rd_frag   (rd_frag),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_err    (rd_err),
        .frag_done (frag_done),
        .clr       (clr)
    );

    // Single comparison point: count it and report any difference.
    task automatic checkOutput(input string tag, input logic [DW-1:0] obs,
                               input logic [DW-1:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
                     tag, cyc, obs, exp);
        end
    endtask

    // Byte address a beat really writes: the running stream address when
    // streaming continues, otherwise the presented address modulo memory size.
    function automatic int effAddr(input logic [AW-1:0] a, input bit s);
        return (in_stream && s) ? next_ptr : int'(a) % MEMB;
    endfunction

    // Drive one cycle of inputs, check every output against the model, then
    // advance the model by what was accepted and step to the next cycle.
    task automatic applyStimulus(input bit r, input bit wv,
                                 input logic [AW-1:0] wa, input logic [7:0] wd,
                                 input bit ws, input bit rq,
                                 input logic [6:0] rf, input bit cl);
        int    ea;
        bit    exp_rdy;
        bit    exp_v;
        resp_t rs;
        rst       = r;
        wr_valid  = wv;
        wr_addr   = wa;
        wr_data   = wd;
        wr_stream = ws;
        rd_req    = rq;
        rd_frag   = rf;
        clr       = cl;
        #2;
        ea      = effAddr(wa, ws);
        exp_rdy = 1'b0;
        if (r) begin
            checkOutput("rst_wr_ready",  wr_ready,  '0);
            checkOutput("rst_rd_ready",  rd_ready,  '0);
            checkOutput("rst_rd_valid",  rd_valid,  '0);
            checkOutput("rst_rd_data",   rd_data,   '0);
            checkOutput("rst_rd_err",    rd_err,    '0);
            checkOutput("rst_frag_done", frag_done, '0);
        end else begin
            exp_rdy = !(wv && (ea / FB) == int'(rf));
            exp_v   = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                rs        = pend.pop_front();
                exp_v     = 1'b1;
                last_data = rs.data;
                last_mask = rs.mask;
                last_err  = rs.err;
            end
            checkOutput("wr_ready",  wr_ready,  DW'(1'b1));
            checkOutput("rd_ready",  rd_ready,  DW'(exp_rdy));
            checkOutput("rd_valid",  rd_valid,  DW'(exp_v));
            checkOutput("rd_data",   rd_data & last_mask, last_data & last_mask);
            checkOutput("rd_err",    rd_err,    DW'(last_err));
            checkOutput("frag_done", frag_done, DW'(fd_next));
        end
        if (r) begin
            pend.delete();
            in_stream = 1'b0;
            fd_next   = 1'b0;
            last_data = '0;
            last_mask = '1;
            last_err  = 1'b0;
            for (int f = 0; f < NF; f++) done_m[f] = 1'b0;
        end else begin
            if (rq && exp_rdy) begin
                for (int b = 0; b < FB; b++) begin
                    rs.data[8*b +: 8] = mem_m[int'(rf)*FB + b];
                    rs.mask[8*b +: 8] = known_m[int'(rf)*FB + b] ? 8'hFF : 8'h00;
                end
                rs.err = !done_m[rf];
                rs.due = cyc + 2;
                pend.push_back(rs);
            end
            fd_next = 1'b0;
            if (wv) begin
                mem_m[ea]   = wd;
                known_m[ea] = 1'b1;
                if (ea % FB == 0)      done_m[ea / FB] = 1'b0;
                if (ea % FB == FB - 1) begin
                    done_m[ea / FB] = 1'b1;
                    fd_next         = 1'b1;
                end
                in_stream = ws;
                next_ptr  = (ea + 1) % MEMB;
            end
            if (cl) begin
                in_stream = 1'b0;
                for (int f = 0; f < NF; f++) done_m[f] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Quiet cycles with nothing requested.
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, 0, '0, 0);
    endtask

    // Directed scenarios first, then randomized traffic with occasional
    // clears and resets, then the summary.
    initial begin
        int fsel;
        logic [AW-1:0] ra;
        for (int i = 0; i < MEMB; i++) known_m[i] = 1'b0;
        for (int f = 0; f < NF; f++) done_m[f] = 1'b0;

        // Reset with traffic presented: nothing may be accepted.
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 16'h0040, 8'h11, 1, 1, 7'd2, 0);

        // Stream 0x00..0x1F from 0x0040, later beats carry junk addresses.
        for (int i = 0; i < 32; i++)
            applyStimulus(0, 1, (i == 0) ? 16'h0040 : AW'($urandom), 8'(i), 1, 0, '0, 0);
        idleCycles(1);
        applyStimulus(0, 0, '0, '0, 0, 1, 7'd2, 0);
        idleCycles(3);

        // Leave stream mode, then stream across the top of memory.
        applyStimulus(0, 1, 16'd4093, 8'h5A, 0, 0, '0, 0);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, (i == 0) ? 16'd4094 : 16'h0123, 8'hC0 + 8'(i), 1, 0, '0, 0);
        applyStimulus(0, 0, '0, '0, 0, 1, 7'd127, 0);
        applyStimulus(0, 0, '0, '0, 0, 1, 7'd0, 0);
        idleCycles(3);

        // Write beats a read of the same fragment; the retried read sees it.
        applyStimulus(0, 1, 16'(5*FB + 7), 8'hA5, 0, 1, 7'd5, 0);
        applyStimulus(0, 0, '0, '0, 0, 1, 7'd5, 0);
        idleCycles(3);

        // Complete frag 3, then complete it again together with clr.
        applyStimulus(0, 1, 16'(3*FB + 31), 8'h77, 0, 0, '0, 0);
        applyStimulus(0, 1, 16'(3*FB + 31), 8'h3C, 0, 0, '0, 1);
        applyStimulus(0, 0, '0, '0, 0, 1, 7'd3, 0);
        idleCycles(3);

        // Back-to-back reads.
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, '0, 0, 1, 7'(i), 0);
        idleCycles(3);

        // Reset with two reads in flight.
        applyStimulus(0, 0, '0, '0, 0, 1, 7'd4, 0);
        applyStimulus(0, 0, '0, '0, 0, 1, 7'd5, 0);
        applyStimulus(1, 0, '0, '0, 0, 0, '0, 0);
        applyStimulus(1, 0, '0, '0, 0, 0, '0, 0);
        idleCycles(4);

        // Randomized traffic on a handful of fragments to force conflicts.
        for (int i = 0; i < 800; i++) begin
            fsel = pick_frag[$urandom_range(0, 5)];
            ra   = AW'(($urandom_range(0, 15) << 12) | (fsel << 5)
                       | (($urandom_range(0, 3) == 0) ? 31 : $urandom_range(0, 31)));
            applyStimulus(($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 2) != 0), ra, 8'($urandom),
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1,
                          7'(pick_frag[$urandom_range(0, 5)]),
                          ($urandom_range(0, 39) == 0));
        end
        idleCycles(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
